// File: rtl/us_pkg.sv
// Shared constants and FSM encoding for the ultrasonic transmit sequencer
// and the downstream wind-direction receiver.
package us_pkg;

  localparam int unsigned US_HALFPER = 1250;
  localparam int unsigned US_NPULSES = 8;
  localparam int unsigned US_SMPDIV  = 10;
  localparam int unsigned US_RXLEN   = 2000;
  localparam int unsigned US_GAPLEN  = 100000;
  localparam int unsigned US_NSHOTS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOT = 2'd1,
    ST_GAP  = 2'd2
  } us_state_e;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned us_cntw(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/us_carrier.sv
// Burst carrier: half-period counter plus phase flop; runs a fixed number of
// half-periods after enable rises, then goes quiet until enable drops.
module us_carrier import us_pkg::*; #(
  parameter int unsigned HALFPER = US_HALFPER,
  parameter int unsigned NHALF   = 2 * US_NPULSES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_active,
  output logic o_phase
);

  localparam int unsigned HW = us_cntw(HALFPER);
  localparam int unsigned NW = $clog2(NHALF + 1);

  logic [HW-1:0] r_hcnt;
  logic [NW-1:0] r_nhalf;
  logic          r_phase;
  logic          w_running;
  logic          w_tc;

  assign w_running = i_en && (r_nhalf != NW'(NHALF));
  assign w_tc      = w_running && (r_hcnt == HW'(HALFPER - 1));

  // Dropping enable re-arms the carrier so the next burst starts high.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_hcnt  <= '0;
      r_nhalf <= '0;
      r_phase <= 1'b1;
    end else if (w_tc) begin
      r_hcnt  <= '0;
      r_nhalf <= r_nhalf + NW'(1);
      r_phase <= ~r_phase;
    end else if (w_running) begin
      r_hcnt  <= r_hcnt + HW'(1);
    end
  end

  assign o_active = w_running;
  assign o_phase  = r_phase;

endmodule

// File: rtl/us_txseq.sv
// Four-shot ultrasonic measurement sequencer: per shot, one transducer bursts
// while receive-sample strobes are issued; shots are separated by dead time.
module us_txseq import us_pkg::*; #(
  parameter int unsigned HALFPER = US_HALFPER,
  parameter int unsigned NPULSES = US_NPULSES,
  parameter int unsigned SMPDIV  = US_SMPDIV,
  parameter int unsigned RXLEN   = US_RXLEN,
  parameter int unsigned GAPLEN  = US_GAPLEN,
  localparam int unsigned RXW    = us_cntw(RXLEN)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  output logic [3:0]     txp,
  output logic [3:0]     txn,
  output logic           endata,
  output logic [RXW-1:0] rxidx,
  output logic [1:0]     shot,
  output logic           busy,
  output logic           done,
  output us_state_e      state_dbg
);

  localparam int unsigned SUBW = us_cntw(SMPDIV);
  localparam int unsigned GW   = us_cntw(GAPLEN);

  if ((2 * NPULSES * HALFPER > RXLEN * SMPDIV) || (SMPDIV < 2) || (GAPLEN < 1)) begin : g_param_check
    $error("us_txseq: burst longer than shot, SMPDIV < 2 or GAPLEN < 1");
  end

  us_state_e      r_state;
  us_state_e      w_state_nxt;
  logic           r_done;
  logic           w_done_nxt;
  logic [SUBW-1:0] r_sub;
  logic [RXW-1:0] r_smp;
  logic [GW-1:0]  r_gcnt;
  logic [1:0]     r_shot;
  logic           w_smp_tick;
  logic           w_shot_end;
  logic           w_gap_end;
  logic           w_car_active;
  logic           w_car_phase;

  assign w_smp_tick = (r_sub == SUBW'(SMPDIV - 1));
  assign w_shot_end = (r_state == ST_SHOT) && w_smp_tick && (r_smp == RXW'(RXLEN - 1));
  assign w_gap_end  = (r_state == ST_GAP) && (r_gcnt == GW'(GAPLEN - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // abort outranks everything but reset, including a same-cycle start.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) w_state_nxt = ST_SHOT;
        ST_SHOT: begin
          if (w_shot_end) begin
            if (r_shot == 2'd3) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_GAP;
            end
          end
        end
        ST_GAP:  if (w_gap_end) w_state_nxt = ST_SHOT;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Sample counters hold through GAP so rxidx keeps the last strobe index.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sub <= '0;
      r_smp <= '0;
    end else if ((r_state == ST_SHOT) && (w_state_nxt == ST_SHOT)) begin
      if (w_smp_tick) begin
        r_sub <= '0;
        r_smp <= r_smp + RXW'(1);
      end else begin
        r_sub <= r_sub + SUBW'(1);
      end
    end else if ((w_state_nxt == ST_SHOT) || (w_state_nxt == ST_IDLE)) begin
      r_sub <= '0;
      r_smp <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_gcnt <= '0;
      r_shot <= 2'd0;
    end else begin
      if ((r_state == ST_GAP) && (w_state_nxt == ST_GAP)) r_gcnt <= r_gcnt + GW'(1);
      else                                                r_gcnt <= '0;
      if (w_state_nxt == ST_IDLE)                                   r_shot <= 2'd0;
      else if ((r_state == ST_GAP) && (w_state_nxt == ST_SHOT))     r_shot <= r_shot + 2'd1;
    end
  end

  us_carrier #(
    .HALFPER (HALFPER),
    .NHALF   (2 * NPULSES)
  ) u_carrier (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_en     (r_state == ST_SHOT),
    .o_active (w_car_active),
    .o_phase  (w_car_phase)
  );

  always_comb begin
    txp = 4'b0000;
    txn = 4'b0000;
    if (w_car_active) begin
      txp[r_shot] = w_car_phase;
      txn[r_shot] = ~w_car_phase;
    end
  end

  assign endata    = (r_state == ST_SHOT) && (r_sub == '0);
  assign rxidx     = r_smp;
  assign shot      = r_shot;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign state_dbg = r_state;

endmodule
